sample_sender: RTL and testbench

SAMPLE_SENDER -- requirements
Module: sample_sender

---
 rtl/sample_sender.sv | 138 +++++++++++++
 tb/tb_sample_sender.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sample_sender.sv
// Streams NUM_SAMPLES words from a synchronous sample memory to a byte-wide
// UART transmitter, most significant byte first, one byte per iTxDone handshake.
module sample_sender #(
    parameter int unsigned NUM_SAMPLES = 256,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 16
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iStartSending,
    output logic [ADDR_W-1:0] oMemAddr,
    input  logic [DATA_W-1:0] iMemData,
    output logic [7:0]        oTxData,
    output logic              oTxStart,
    input  logic              iTxDone,
    output logic              oBusy,
    output logic              oSendingDone
);

    localparam int unsigned BYTES  = DATA_W / 8;
    localparam int unsigned BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_SAMPLES - 1);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] READ      = 3'd1;
    localparam logic [2:0] LATCH     = 3'd2;
    localparam logic [2:0] SEND      = 3'd3;
    localparam logic [2:0] WAIT_TX   = 3'd4;
    localparam logic [2:0] NEXT_BYTE = 3'd5;
    localparam logic [2:0] NEXT_WORD = 3'd6;
    localparam logic [2:0] DONE      = 3'd7;

    logic [2:0]        state, state_next;
    logic [ADDR_W-1:0] word_cnt, word_next;
    logic [BCNT_W-1:0] byte_cnt, byte_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic [ADDR_W-1:0] addr_next;
    logic [7:0]        tx_data_next;
    logic              tx_start_next;
    logic              busy_next;
    logic              done_next;

    // Register state, counters, shift register and every output.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state        <= IDLE;
            word_cnt     <= '0;
            byte_cnt     <= '0;
            shift_reg    <= '0;
            oMemAddr     <= '0;
            oTxData      <= '0;
            oTxStart     <= 1'b0;
            oBusy        <= 1'b0;
            oSendingDone <= 1'b0;
        end else begin
            state        <= state_next;
            word_cnt     <= word_next;
            byte_cnt     <= byte_next;
            shift_reg    <= shift_next;
            oMemAddr     <= addr_next;
            oTxData      <= tx_data_next;
            oTxStart     <= tx_start_next;
            oBusy        <= busy_next;
            oSendingDone <= done_next;
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so that oTxStart/oTxData are valid while the FSM sits in SEND.
    always_comb begin
        state_next = state;
        word_next  = word_cnt;
        byte_next  = byte_cnt;
        shift_next = shift_reg;
        addr_next  = oMemAddr;
        busy_next  = oBusy;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                if (iStartSending) begin
                    word_next  = '0;
                    addr_next  = '0;
                    busy_next  = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
                // memory read latency
                state_next = LATCH;
            end
            LATCH: begin
                shift_next = iMemData;
                byte_next  = '0;
                state_next = SEND;
            end
            SEND: begin
                state_next = WAIT_TX;
            end
            WAIT_TX: begin
                if (iTxDone) begin
                    if (byte_cnt != LAST_BYTE) begin
                        state_next = NEXT_BYTE;
                    end else if (word_cnt != LAST_WORD) begin
                        state_next = NEXT_WORD;
                    end else begin
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            NEXT_BYTE: begin
                shift_next = shift_reg << 8;
                byte_next  = byte_cnt + 1'b1;
                state_next = SEND;
            end
            NEXT_WORD: begin
                // only reached when word_cnt < LAST_WORD, so no wrap
                word_next  = word_cnt + 1'b1;
                addr_next  = oMemAddr + 1'b1;
                state_next = READ;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        tx_start_next = (state_next == SEND);
        tx_data_next  = tx_start_next ? shift_next[DATA_W-1 -: 8] : oTxData;
    end

endmodule

// File: tb/tb_sample_sender.sv
// Directed bench for sample_sender with a 4-word, 2-bit-address configuration.
module tb_sample_sender;

    localparam int unsigned NUM_SAMPLES = 4;
    localparam int unsigned ADDR_W      = 2;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned NBYTES      = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start = 1'b0;
    logic              tx_done = 1'b0;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] mem_data = '0;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              busy;
    logic              sending_done;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;
    int start_cnt = 0;
    int done_cnt  = 0;
    int max_addr  = 0;

    typedef struct {
        bit         start_pulse;
        bit         spurious_done;
        logic [7:0] exp_data;
        int         exp_addr;
    } vec_t;

    vec_t vecs [NBYTES];

    sample_sender #(
        .NUM_SAMPLES(NUM_SAMPLES),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W)
    ) dut (
        .iClock       (clk),
        .iReset       (rst),
        .iStartSending(start),
        .oMemAddr     (addr),
        .iMemData     (mem_data),
        .oTxData      (tx_data),
        .oTxStart     (tx_start),
        .iTxDone      (tx_done),
        .oBusy        (busy),
        .oSendingDone (sending_done)
    );

    always #5 clk = ~clk;

    // Synchronous memory model, mem[i] = 16'hA0B0 + i, plus edge counter.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        mem_data <= 16'hA0B0 + 16'(addr);
    end

    // Output event counters.
    always @(posedge clk) begin
        #1;
        if (tx_start) start_cnt = start_cnt + 1;
        if (sending_done) done_cnt = done_cnt + 1;
        if (int'(addr) > max_addr) max_addr = int'(addr);
    end

    task automatic check(input string name, input int act, input int exp);
        total = total + 1;
        if (act == exp) passed = passed + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One full run driven from the vector table; caller must be on a negedge.
    task automatic run_table(input string tag);
        int  last_cyc;
        int  prev_addr;
        int  extra;
        bit  got;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_on_start"}, int'(busy), 1);
        check({tag, "_addr_on_start"}, int'(addr), 0);
        last_cyc  = cyc;
        prev_addr = int'(addr);
        for (int k = 0; k < int'(NBYTES); k++) begin
            got = 1'b0;
            for (int w = 0; w < 40 && !got; w++) begin
                if (tx_start) begin
                    got = 1'b1;
                end else begin
                    tick();
                    tx_done = 1'b0;
                    if (int'(addr) != prev_addr) begin
                        last_cyc  = cyc;
                        prev_addr = int'(addr);
                    end
                end
            end
            check($sformatf("%s_txstart_seen_%0d", tag, k), int'(got), 1);
            check($sformatf("%s_txdata_%0d", tag, k), int'(tx_data), int'(vecs[k].exp_data));
            check($sformatf("%s_addr_%0d", tag, k), int'(addr), vecs[k].exp_addr);
            // oTxStart lands in the third cycle after the address load (READ, LATCH, SEND)
            if (k % 2 == 0)
                check($sformatf("%s_latency_%0d", tag, k), cyc - last_cyc, 2);
            if (vecs[k].spurious_done) tx_done = 1'b1;
            extra = 0;
            for (int i = 1; i <= 10; i++) begin
                tick();
                tx_done = (i == 10);
                start   = vecs[k].start_pulse && (i == 4);
                if (tx_start) extra = extra + 1;
            end
            start = 1'b0;
            check($sformatf("%s_no_extra_start_%0d", tag, k), extra, 0);
        end
        got = 1'b0;
        for (int w = 0; w < 40 && !got; w++) begin
            tick();
            tx_done = 1'b0;
            if (sending_done) got = 1'b1;
        end
        check({tag, "_sending_done_seen"}, int'(got), 1);
        check({tag, "_busy_in_done"}, int'(busy), 0);
        // start pulse during the DONE cycle must be ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check({tag, "_busy_after_done"}, int'(busy), 0);
        check({tag, "_txstart_after_done"}, int'(tx_start), 0);
        check({tag, "_addr_final"}, int'(addr), int'(NUM_SAMPLES - 1));
    endtask

    initial begin
        int  cd;
        bit  hit;
        int  d0;

        vecs[0] = '{1'b0, 1'b0, 8'hA0, 0};
        vecs[1] = '{1'b0, 1'b1, 8'hB0, 0};
        vecs[2] = '{1'b1, 1'b0, 8'hA0, 1};
        vecs[3] = '{1'b0, 1'b0, 8'hB1, 1};
        vecs[4] = '{1'b0, 1'b0, 8'hA0, 2};
        vecs[5] = '{1'b1, 1'b0, 8'hB2, 2};
        vecs[6] = '{1'b0, 1'b1, 8'hA0, 3};
        vecs[7] = '{1'b0, 1'b0, 8'hB3, 3};

        rst = 1'b1;
        tick();
        check("rst_addr", int'(addr), 0);
        check("rst_txdata", int'(tx_data), 0);
        check("rst_txstart", int'(tx_start), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(sending_done), 0);
        tick();
        rst = 1'b0;

        // Spurious iTxDone while idle.
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        tick();
        check("idle_spurious_busy", int'(busy), 0);
        check("idle_spurious_starts", start_cnt, 0);

        run_table("run1");
        check("run1_start_count", start_cnt, 8);
        check("run1_done_count", done_cnt, 1);
        check("run1_max_addr", max_addr, 3);

        // Partial run aborted by an asynchronous reset in WAIT_TX of word 2.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("abort_addr_on_start", int'(addr), 0);
        cd  = 0;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            tick();
            tx_done = 1'b0;
            if (cd > 0) begin
                cd = cd - 1;
                if (cd == 0) tx_done = 1'b1;
            end
            if (tx_start) begin
                if (int'(addr) == 2) hit = 1'b1;
                else cd = 10;
            end
        end
        check("abort_reached_word2", int'(hit), 1);
        tx_done = 1'b0;
        tick();
        tick();
        tick();
        d0 = done_cnt;
        #2;
        rst = 1'b1;
        #1;
        check("abort_addr", int'(addr), 0);
        check("abort_txdata", int'(tx_data), 0);
        check("abort_txstart", int'(tx_start), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(sending_done), 0);
        tick();
        tick();
        check("abort_no_done_pulse", done_cnt, d0);
        rst = 1'b0;
        // start on the first edge after release
        run_table("run2");
        check("total_start_count", start_cnt, 21);
        check("total_done_count", done_cnt, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
